// File: rtl/tap_accumulator.sv
// tap_accumulator
//   Sums NUM_PARTIALS consecutive unsigned partials from the FIR multiply-add
//   tree into one sample. The sum is right-shifted by SHIFT, clipped to
//   OUT_WIDTH bits and then held behind a valid/ready handshake.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-low reset
//   clear      synchronous flush of the partial sum and of the held output
//   in_valid   in_data carries a partial this cycle
//   in_ready   block accepts a partial this cycle
//   in_data    unsigned partial sum, DATA_WIDTH+COEFF_WIDTH+2 bits
//   out_valid  out_data holds a completed sample
//   out_ready  sink takes out_data this cycle
//   out_data   scaled, saturated sample
//   out_sat    out_data was clipped (qualified by out_valid)
module tap_accumulator #(
   parameter int DATA_WIDTH   = 8,
   parameter int COEFF_WIDTH  = 8,
   parameter int NUM_PARTIALS = 4,
   parameter int SHIFT        = 2,
   parameter int OUT_WIDTH    = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                clear,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_WIDTH+COEFF_WIDTH+1:0]   in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [OUT_WIDTH-1:0]                out_data,
   output logic                                out_sat
);

   localparam int IN_WIDTH  = DATA_WIDTH + COEFF_WIDTH + 2;
   localparam int ACC_WIDTH = IN_WIDTH + $clog2(NUM_PARTIALS) + 1;
   // A single-partial group still needs a one-bit counter to stay legal.
   localparam int CNT_WIDTH = (NUM_PARTIALS > 1) ? $clog2(NUM_PARTIALS) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NUM_PARTIALS - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                 state_reg, state_next;
   logic [ACC_WIDTH-1:0]   acc_reg;
   logic [CNT_WIDTH-1:0]   cnt_reg;
   logic [OUT_WIDTH-1:0]   out_data_reg;
   logic                   out_sat_reg;

   logic                   accept;
   logic                   last_partial;
   logic                   group_done;
   logic [ACC_WIDTH-1:0]   in_ext;
   logic [ACC_WIDTH-1:0]   acc_next;
   logic [ACC_WIDTH-1:0]   scaled;
   logic [OUT_WIDTH-1:0]   sat_data;
   logic                   sat_flag;

   // A new partial can enter whenever the output slot is empty or is being
   // drained in this same cycle.
   assign in_ready     = (state_reg == EMPTY) | out_ready;
   assign accept       = in_valid & in_ready;
   assign last_partial = (cnt_reg == CNT_LAST);
   assign group_done   = accept & last_partial & ~clear;

   // The accumulator is wide enough for NUM_PARTIALS full-scale partials, so
   // the sum never wraps; the first partial of a group overwrites stale data.
   assign in_ext   = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, in_data};
   assign acc_next = (cnt_reg == '0) ? in_ext : (acc_reg + in_ext);
   assign scaled   = acc_next >> SHIFT;

   generate
      if (ACC_WIDTH > OUT_WIDTH) begin : g_clip
         assign sat_flag = |scaled[ACC_WIDTH-1:OUT_WIDTH];
         assign sat_data = sat_flag ? {OUT_WIDTH{1'b1}} : scaled[OUT_WIDTH-1:0];
      end else begin : g_fit
         assign sat_flag = 1'b0;
         assign sat_data = OUT_WIDTH'(scaled);
      end
   endgenerate

   // Output-slot state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: a completed group always (re)fills the slot, which gives
   // back-to-back output when it coincides with a handshake.
   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = EMPTY;
      end else if (group_done) begin
         state_next = FULL;
      end else if ((state_reg == FULL) && out_ready) begin
         state_next = EMPTY;
      end
   end

   // Accumulation datapath and held result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_reg      <= '0;
         cnt_reg      <= '0;
         out_data_reg <= '0;
         out_sat_reg  <= 1'b0;
      end else if (clear) begin
         acc_reg      <= '0;
         cnt_reg      <= '0;
         out_data_reg <= '0;
         out_sat_reg  <= 1'b0;
      end else if (accept) begin
         if (last_partial) begin
            cnt_reg      <= '0;
            out_data_reg <= sat_data;
            out_sat_reg  <= sat_flag;
         end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
         end
      end
   end

   assign out_valid = (state_reg == FULL);
   assign out_data  = out_data_reg;
   assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_tap_accumulator.sv
module tb_tap_accumulator;

   localparam int IN_W  = 18;
   localparam int OUT_W = 16;
   localparam int NP    = 4;
   localparam int SH    = 2;

   typedef struct {
      int unsigned data;
      bit          sat;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_sat;

   tap_accumulator #(
      .DATA_WIDTH(8), .COEFF_WIDTH(8), .NUM_PARTIALS(NP), .SHIFT(SH), .OUT_WIDTH(OUT_W)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   // Reference model state: partials of the open group, plus whether the
   // sink still owes us a handshake for the last completed sample.
   exp_t        exp_q[$];
   longint      grp_sum;
   int          grp_n;
   bit          model_full;
   bit          mon_en;
   int          n_chk;
   int          n_fail;
   int          n_pop;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      grp_sum    = 0;
      grp_n      = 0;
      model_full = 1'b0;
      exp_q.delete();
   endtask

   // One cycle of stimulus, entered and left at posedge+1.
   task automatic drive(input bit v, input int unsigned d, input bit ordy, input bit clr);
      bit     rdy;
      bit     acc;
      longint scaled;
      exp_t   e;
      in_valid  = v;
      in_data   = IN_W'(d);
      out_ready = ordy;
      clear     = clr;
      rdy = !model_full || ordy;
      acc = v && rdy && !clr;
      $display("cycle: v=%0b d=%0d ordy=%0b clr=%0b accept=%0b", v, d, ordy, clr, acc);
      @(posedge clk);
      if (clr) begin
         if (model_full && !ordy) void'(exp_q.pop_back());
         grp_sum    = 0;
         grp_n      = 0;
         model_full = 1'b0;
      end else begin
         if (model_full && ordy) model_full = 1'b0;
         if (acc) begin
            grp_sum += d;
            grp_n++;
            if (grp_n == NP) begin
               scaled = grp_sum >>> SH;
               e.sat  = (scaled > 65535);
               e.data = e.sat ? 32'd65535 : int'(scaled);
               exp_q.push_back(e);
               model_full = 1'b1;
               grp_sum = 0;
               grp_n   = 0;
            end
         end
      end
      #1;
   endtask

   task automatic peek(input string name, input bit v, input int unsigned d, input bit s);
      #1;
      chk({name, ".valid"}, out_valid, v);
      chk({name, ".data"}, out_data, d);
      chk({name, ".sat"}, out_sat, s);
   endtask

   // Monitor: every cycle the held result, out_valid and in_ready must match
   // the scoreboard; a handshake retires the front entry.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon.in_ready", in_ready, ((exp_q.size() == 0) || out_ready) ? 1 : 0);
         chk("mon.out_valid", out_valid, (exp_q.size() != 0) ? 1 : 0);
         if (out_valid && exp_q.size() != 0) begin
            chk("mon.out_data", out_data, exp_q[0].data);
            chk("mon.out_sat", out_sat, exp_q[0].sat);
            if (out_ready) begin
               $display("sample: data=%0d sat=%0b", out_data, out_sat);
               void'(exp_q.pop_front());
               n_pop++;
            end
         end
      end
   end

   initial begin
      n_chk = 0; n_fail = 0; n_pop = 0; mon_en = 0;
      model_reset();
      reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("reset.out_valid", out_valid, 0);
      chk("reset.out_data", out_data, 0);
      chk("reset.out_sat", out_sat, 0);
      chk("reset.in_ready", in_ready, 1);
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Basic group: (100+200+300+400)>>2
      drive(1, 100, 1, 0); drive(1, 200, 1, 0); drive(1, 300, 1, 0);
      peek("basic.pre", 0, 0, 0);
      drive(1, 400, 1, 0);
      peek("basic", 1, 250, 0);
      drive(0, 0, 1, 0);
      peek("basic.one_cycle", 0, 250, 0);

      // Saturation
      repeat (4) drive(1, 18'h3FFFF, 1, 0);
      peek("sat", 1, 16'hFFFF, 1);
      drive(0, 0, 1, 0);

      // Backpressure
      repeat (4) drive(1, 4, 1, 0);
      peek("bp.first", 1, 4, 0);
      repeat (5) begin
         drive(1, 8, 0, 0);
         #1 chk("bp.in_ready", in_ready, 0);
         chk("bp.hold", out_data, 4);
      end
      drive(1, 8, 1, 0);
      repeat (3) drive(1, 8, 1, 0);
      peek("bp.next", 1, 8, 0);
      drive(0, 0, 1, 0);

      // Asynchronous reset mid-group
      drive(1, 1000, 1, 0); drive(1, 1000, 1, 0);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk); #1;
      repeat (4) drive(1, 16, 1, 0);
      peek("rst_mid", 1, 16, 0);
      drive(0, 0, 1, 0);

      // clear mid-group
      repeat (3) drive(1, 500, 1, 0);
      drive(1, 500, 1, 1);
      repeat (4) drive(1, 40, 1, 0);
      peek("clear.group", 1, 40, 0);
      // clear while FULL and stalled
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      peek("clear.full", 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0,
               $urandom_range(0, 1) ? $urandom_range(0, 1000) : $urandom_range(0, 18'h3FFFF),
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 39) == 0);
      end
      repeat (3) drive(0, 0, 1, 0);
      chk("drain.empty", exp_q.size(), 0);
      chk("drain.seen", (n_pop > 10) ? 1 : 0, 1);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
